ingame_fsm: RTL and testbench

INGAME_FSM -- requirements
Module: ingame_fsm

---
 rtl/ingame_fsm.sv | 108 ++++++++++
 tb/tb_ingame_fsm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingame_fsm.sv
// ingame_fsm: memory-match round controller (pick two tiles, compare, show mismatches, detect win/loss).
module ingame_fsm #(
  parameter logic [47:0] LAYOUT = {3'd7, 3'd7, 3'd6, 3'd6, 3'd5, 3'd5, 3'd4, 3'd4,
                                   3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0},
  parameter int SHOW_CYCLES = 25000000,
  parameter int MAX_MOVES = 40
) (
  input  logic        CLOCK_50,
  input  logic        userquit,
  input  logic        ingameOn,
  input  logic [3:0]  tileSel,
  input  logic        keyselect,
  output logic [15:0] revealed,
  output logic [15:0] matched,
  output logic [6:0]  movesCount,
  output logic [3:0]  pairsLeft,
  output logic        gameOver,
  output logic        win
);
  typedef enum logic [2:0] {IDLE, PICK1, PICK2, COMPARE, SHOW, OVER} state_t;
  localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    first_q, second_q;
  logic          key_q;
  logic [2:0]    val [16];
  logic          ev, same;
  logic [6:0]    moves_d;
  for (genvar k = 0; k < 16; k++) begin : g_val
    assign val[k] = LAYOUT[3*k +: 3];
  end
  always_comb begin
    ev = keyselect & ~key_q;
    same = val[first_q] == val[second_q];
    moves_d = (movesCount == 7'd127) ? movesCount : movesCount + 7'd1;
  end
  // IDLE and a dropped ingameOn share one clearing path so abandoning a game needs no extra state
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      state_q    <= IDLE;
      revealed   <= '0;
      matched    <= '0;
      movesCount <= '0;
      pairsLeft  <= 4'd8;
      gameOver   <= 1'b0;
      win        <= 1'b0;
      timer_q    <= '0;
      first_q    <= '0;
      second_q   <= '0;
      key_q      <= 1'b0;
    end else begin
      key_q <= keyselect;
      if (state_q == IDLE || !ingameOn) begin
        state_q    <= ingameOn ? PICK1 : IDLE;
        revealed   <= '0;
        matched    <= '0;
        movesCount <= '0;
        pairsLeft  <= 4'd8;
        gameOver   <= 1'b0;
        win        <= 1'b0;
        timer_q    <= '0;
        first_q    <= '0;
        second_q   <= '0;
      end else begin
        case (state_q)
          PICK1: if (ev && !revealed[tileSel]) begin
            first_q           <= tileSel;
            revealed[tileSel] <= 1'b1;
            state_q           <= PICK2;
          end
          PICK2: if (ev && !revealed[tileSel]) begin
            second_q          <= tileSel;
            revealed[tileSel] <= 1'b1;
            state_q           <= COMPARE;
          end
          COMPARE: begin
            movesCount <= moves_d;
            if (same) begin
              matched[first_q]  <= 1'b1;
              matched[second_q] <= 1'b1;
              pairsLeft         <= pairsLeft - 4'd1;
              if (pairsLeft == 4'd1) begin
                state_q  <= OVER;
                gameOver <= 1'b1;
                win      <= 1'b1;
              end else if (moves_d == 7'(MAX_MOVES)) begin
                state_q  <= OVER;
                gameOver <= 1'b1;
              end else state_q <= PICK1;
            end else if (moves_d == 7'(MAX_MOVES)) begin
              state_q  <= OVER;
              gameOver <= 1'b1;
            end else begin
              timer_q <= TW'(SHOW_CYCLES - 1);
              state_q <= SHOW;
            end
          end
          SHOW: if (timer_q == '0) begin
            revealed[first_q]  <= 1'b0;
            revealed[second_q] <= 1'b0;
            state_q            <= PICK1;
          end else timer_q <= timer_q - 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ingame_fsm.sv
// tb_ingame_fsm: randomized and directed checks of ingame_fsm against a game-level reference model.
module tb_ingame_fsm;
  localparam int MAXM = 3;
  localparam logic [44:0] RST_V = {16'h0, 16'h0, 7'd0, 4'd8, 2'b00};
  logic clk = 1'b0;
  logic userquit, ingameOn, keyselect;
  logic [3:0] tileSel;
  logic [15:0] revealed, matched, w_revealed, w_matched;
  logic [6:0] movesCount, w_movesCount;
  logic [3:0] pairsLeft, w_pairsLeft;
  logic gameOver, win, w_gameOver, w_win;
  logic [44:0] outv, w_outv;
  int checks = 0, errors = 0;
  logic [15:0] m_rev, m_mat;
  int m_moves, m_first, m_second, m_pend, m_delay;
  bit m_over, m_win, m_on, m_kprev;

  ingame_fsm #(.SHOW_CYCLES(4), .MAX_MOVES(MAXM)) dut (
    .CLOCK_50(clk), .userquit(userquit), .ingameOn(ingameOn), .tileSel(tileSel),
    .keyselect(keyselect), .revealed(revealed), .matched(matched), .movesCount(movesCount),
    .pairsLeft(pairsLeft), .gameOver(gameOver), .win(win));
  ingame_fsm #(.SHOW_CYCLES(4), .MAX_MOVES(127)) dut_w (
    .CLOCK_50(clk), .userquit(userquit), .ingameOn(ingameOn), .tileSel(tileSel),
    .keyselect(keyselect), .revealed(w_revealed), .matched(w_matched), .movesCount(w_movesCount),
    .pairsLeft(w_pairsLeft), .gameOver(w_gameOver), .win(w_win));

  always #5 clk = ~clk;
  assign outv   = {revealed, matched, movesCount, pairsLeft, gameOver, win};
  assign w_outv = {w_revealed, w_matched, w_movesCount, w_pairsLeft, w_gameOver, w_win};

  function automatic logic [44:0] exp_vec();
    return {m_rev, m_mat, 7'(m_moves), 4'(8 - $countones(m_mat) / 2), m_over, m_win};
  endfunction

  task automatic model_clear();
    m_rev = '0; m_mat = '0; m_moves = 0; m_over = 0; m_win = 0;
    m_on = 0; m_first = -1; m_second = -1; m_pend = 0; m_delay = 0;
  endtask

  // One clock edge of game rules: a pair resolves one edge after its second pick,
  // a mismatched pair is hidden again four edges after that.
  task automatic model_step();
    bit e;
    e = keyselect && !m_kprev;
    m_kprev = keyselect;
    if (!ingameOn) begin model_clear(); return; end
    if (!m_on) begin m_on = 1; return; end
    if (m_over) return;
    if (m_pend != 0) begin
      m_delay--;
      if (m_delay > 0) return;
      if (m_pend == 2) begin
        m_rev[m_first] = 0; m_rev[m_second] = 0; m_pend = 0; m_first = -1;
        return;
      end
      m_moves = (m_moves < 127) ? m_moves + 1 : 127;
      m_pend = 0;
      if ((m_first >> 1) == (m_second >> 1)) begin
        m_mat[m_first] = 1; m_mat[m_second] = 1; m_first = -1;
        if (m_mat == 16'hFFFF) begin m_over = 1; m_win = 1; end
        else if (m_moves == MAXM) m_over = 1;
      end else if (m_moves == MAXM) begin
        m_over = 1; m_first = -1;
      end else begin
        m_pend = 2; m_delay = 4;
      end
      return;
    end
    if (e && !m_rev[tileSel]) begin
      m_rev[tileSel] = 1;
      if (m_first < 0) m_first = int'(tileSel);
      else begin m_second = int'(tileSel); m_pend = 1; m_delay = 1; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] t, input int hold);
    tileSel = t; keyselect = 1;
    repeat (hold) tick();
    keyselect = 0;
    tick();
  endtask

  task automatic do_reset();
    userquit = 1; ingameOn = 0; keyselect = 0; tileSel = 0;
    @(posedge clk);
    @(negedge clk);
    userquit = 0;
    model_clear();
    m_kprev = 0;
  endtask

  task automatic start_game();
    do_reset();
    ingameOn = 1;
    tick();
  endtask

  task automatic test_reset();
    userquit = 1; ingameOn = 0; keyselect = 0; tileSel = 0;
    #1;
    checks++;
    if (outv !== RST_V) begin errors++; $display("FAIL reset_async: got %h expected %h", outv, RST_V); end
    @(negedge clk);
    userquit = 0;
    model_clear(); m_kprev = 0;
    tick();
    checks++;
    if (outv !== RST_V) begin errors++; $display("FAIL reset_idle: got %h expected %h", outv, RST_V); end
  endtask

  task automatic test_match();
    start_game();
    press(0, 1);
    press(1, 1);
    checks++;
    if ({revealed, matched, movesCount, pairsLeft} !== {16'h3, 16'h3, 7'd1, 4'd7}) begin
      errors++;
      $display("FAIL match: got rev=%h mat=%h mv=%0d pl=%0d expected 0003 0003 1 7", revealed, matched, movesCount, pairsLeft);
    end
    checks++;
    if (outv !== exp_vec()) begin errors++; $display("FAIL match_model: got %h expected %h", outv, exp_vec()); end
  endtask

  task automatic test_mismatch();
    start_game();
    press(0, 1);
    press(2, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (revealed !== 16'h0005) begin errors++; $display("FAIL show_cycle%0d: got %h expected 0005", i, revealed); end
      tick();
    end
    checks++;
    if ({revealed, movesCount} !== {16'h0, 7'd1}) begin
      errors++; $display("FAIL show_end: got rev=%h mv=%0d expected 0000 1", revealed, movesCount);
    end
    checks++;
    if (outv !== exp_vec()) begin errors++; $display("FAIL mismatch_model: got %h expected %h", outv, exp_vec()); end
  endtask

  task automatic test_loss();
    start_game();
    press(0, 1); press(2, 1); repeat (4) tick();
    press(0, 1); press(4, 1); repeat (4) tick();
    press(0, 1); press(6, 1);
    checks++;
    if ({gameOver, win, movesCount, revealed} !== {1'b1, 1'b0, 7'd3, 16'h0041}) begin
      errors++;
      $display("FAIL loss: got go=%b w=%b mv=%0d rev=%h expected 1 0 3 0041", gameOver, win, movesCount, revealed);
    end
    press(8, 1);
    checks++;
    if (outv !== exp_vec()) begin errors++; $display("FAIL over_frozen: got %h expected %h", outv, exp_vec()); end
    ingameOn = 0;
    tick();
    checks++;
    if (outv !== RST_V) begin errors++; $display("FAIL loss_exit: got %h expected %h", outv, RST_V); end
  endtask

  task automatic test_win();
    start_game();
    for (int k = 0; k < 8; k++) begin
      press(4'(2 * k), 1);
      press(4'(2 * k + 1), 1);
      checks++;
      if (w_pairsLeft !== 4'(7 - k)) begin errors++; $display("FAIL win_pairs%0d: got %0d expected %0d", k, w_pairsLeft, 7 - k); end
    end
    checks++;
    if ({w_gameOver, w_win, w_pairsLeft, w_movesCount} !== {1'b1, 1'b1, 4'd0, 7'd8}) begin
      errors++;
      $display("FAIL win: got go=%b w=%b pl=%0d mv=%0d expected 1 1 0 8", w_gameOver, w_win, w_pairsLeft, w_movesCount);
    end
    checks++;
    if (outv !== exp_vec()) begin errors++; $display("FAIL win_limit_model: got %h expected %h", outv, exp_vec()); end
    ingameOn = 0;
    tick();
    checks++;
    if ({w_gameOver, w_pairsLeft} !== {1'b0, 4'd8}) begin
      errors++; $display("FAIL win_exit: got go=%b pl=%0d expected 0 8", w_gameOver, w_pairsLeft);
    end
  endtask

  task automatic test_ignored();
    start_game();
    press(5, 1);
    press(5, 1);
    checks++;
    if ({revealed, movesCount} !== {16'h0020, 7'd0}) begin
      errors++; $display("FAIL reselect: got rev=%h mv=%0d expected 0020 0", revealed, movesCount);
    end
    press(7, 10);
    checks++;
    if ({revealed, movesCount} !== {16'h0000, 7'd1}) begin
      errors++; $display("FAIL held_key: got rev=%h mv=%0d expected 0000 1", revealed, movesCount);
    end
    press(0, 1); press(2, 1);
    press(4, 1);
    repeat (2) tick();
    checks++;
    if ({revealed, movesCount} !== {16'h0000, 7'd2}) begin
      errors++; $display("FAIL show_select: got rev=%h mv=%0d expected 0000 2", revealed, movesCount);
    end
    checks++;
    if (outv !== exp_vec()) begin errors++; $display("FAIL ignored_model: got %h expected %h", outv, exp_vec()); end
  endtask

  task automatic test_abandon();
    start_game();
    press(3, 1);
    ingameOn = 0;
    tick();
    checks++;
    if (outv !== RST_V) begin errors++; $display("FAIL abandon: got %h expected %h", outv, RST_V); end
    ingameOn = 1; tick();
    tileSel = 9; keyselect = 1; ingameOn = 0;
    tick();
    ingameOn = 1;
    tick(); tick();
    keyselect = 0;
    tick();
    checks++;
    if (revealed !== 16'h0) begin errors++; $display("FAIL drop_select: got %h expected 0000", revealed); end
    checks++;
    if (outv !== exp_vec()) begin errors++; $display("FAIL abandon_model: got %h expected %h", outv, exp_vec()); end
  endtask

  task automatic test_async_reset();
    start_game();
    press(0, 1); press(2, 1);
    #2 userquit = 1;
    #1;
    checks++;
    if (outv !== RST_V) begin errors++; $display("FAIL async_show: got %h expected %h", outv, RST_V); end
    @(negedge clk);
    userquit = 0;
    model_clear(); m_kprev = 0;
    tick();
    press(0, 1); press(1, 1);
    checks++;
    if (outv !== exp_vec()) begin errors++; $display("FAIL post_reset: got %h expected %h", outv, exp_vec()); end
  endtask

  task automatic test_random();
    start_game();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0 || m_over) begin
        ingameOn = 0; keyselect = 1'($urandom_range(0, 1));
        tick();
        ingameOn = 1; keyselect = 0;
        tick();
      end else begin
        press(4'($urandom_range(0, 15)), $urandom_range(1, 3));
        repeat ($urandom_range(0, 3)) tick();
      end
      checks++;
      if (outv !== exp_vec()) begin errors++; $display("FAIL random%0d: got %h expected %h", i, outv, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_loss();
    test_win();
    test_ignored();
    test_abandon();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
